inst_mem_loader: RTL and testbench

- Boot-time writer for the instruction memory; the core's fetch path is the reader of that memory.
- Accepts a byte stream over a valid/ready handshake and parses a 4-byte length header followed by program words.
- Assembles each word little-endian and issues one single-cycle word write per instruction.
- Holds the core in reset (core_hold) until the whole image is written.

---
 rtl/inst_mem_loader_if.sv | 22 ++
 rtl/inst_mem_loader.sv | 94 +++++++++
 tb/tb_inst_mem_loader.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_loader_if.sv
// Byte-stream receive and instruction-memory write bus
// shared between the boot loader and its environment.
interface inst_mem_loader_if #(
  parameter int n = 32
) ();
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic         rx_ready;
  logic         mem_we;
  logic [n-1:0] mem_addr;
  logic [n-1:0] mem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Boot loader: parses a length header and program bytes,
// writes words to instruction memory, holds core until done.
module inst_mem_loader #(
  parameter int           n         = 32,
  parameter logic [n-1:0] ADDR_BASE = '0,
  parameter int           MAX_WORDS = 64
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               start,
  inst_mem_loader_if.slave   bus,
  output logic               core_hold,
  output logic               done,
  output logic               err,
  output logic [n-1:0]       words_loaded
);

  typedef enum logic [2:0] {
    IDLE, HDR, DATA, WRITE, DONE, ERR
  } state_t;

  state_t       state;
  logic [1:0]   byte_idx;
  logic [n-1:0] len;
  logic [n-1:0] word_idx;
  logic [n-1:0] word;

  logic         xfer;
  logic [n-1:0] len_full;
  logic [n-1:0] idx_inc;

  assign xfer     = bus.rx_valid & bus.rx_ready;
  // header value as it will be once this cycle's byte lands
  assign len_full = {bus.rx_data, len[23:0]};
  assign idx_inc  = word_idx + n'(1);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state    <= IDLE;
      byte_idx <= '0;
      len      <= '0;
      word_idx <= '0;
      word     <= '0;
    end else begin
      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= HDR;
            byte_idx <= '0;
            word_idx <= '0;
            len      <= '0;
          end
        end
        HDR: begin
          if (xfer) begin
            len[8*byte_idx +: 8] <= bus.rx_data;
            byte_idx             <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              if (len_full == '0)
                state <= DONE;
              else if (len_full > n'(MAX_WORDS))
                state <= ERR;
              else
                state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            word[8*byte_idx +: 8] <= bus.rx_data;
            byte_idx              <= byte_idx + 2'd1;
            if (byte_idx == 2'd3)
              state <= WRITE;
          end
        end
        WRITE: begin
          word_idx <= idx_inc;
          state    <= (idx_inc == len) ? DONE : DATA;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rx_ready  = (state == HDR) || (state == DATA);
  assign bus.mem_we    = (state == WRITE);
  assign bus.mem_addr  = ADDR_BASE + (word_idx << 2);
  assign bus.mem_wdata = word;
  assign core_hold     = (state != DONE);
  assign done          = (state == DONE);
  assign err           = (state == ERR);
  assign words_loaded  = word_idx;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: two instances,
// one at base 0 and one at a base that wraps.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        areset;
  logic        start1, start2;
  logic        hold1, done1, err1;
  logic        hold2, done2, err2;
  logic [31:0] wl1, wl2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  inst_mem_loader_if #(.n(32)) bif1 ();
  inst_mem_loader_if #(.n(32)) bif2 ();

  inst_mem_loader #(
    .n(32), .ADDR_BASE(32'h0000_0000), .MAX_WORDS(64)
  ) dut1 (
    .clk(clk), .areset(areset), .start(start1), .bus(bif1),
    .core_hold(hold1), .done(done1), .err(err1),
    .words_loaded(wl1)
  );

  inst_mem_loader #(
    .n(32), .ADDR_BASE(32'hFFFF_FFFC), .MAX_WORDS(64)
  ) dut2 (
    .clk(clk), .areset(areset), .start(start2), .bus(bif2),
    .core_hold(hold2), .done(done2), .err(err2),
    .words_loaded(wl2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // write monitors
  logic [31:0] a1 [0:31];
  logic [31:0] d1 [0:31];
  int          c1 [0:31];
  int          nw1 = 0;
  logic [31:0] a2 [0:31];
  logic [31:0] d2 [0:31];
  int          nw2 = 0;

  always @(negedge clk) begin
    if (bif1.mem_we === 1'b1) begin
      if (nw1 < 32) begin
        a1[nw1] = bif1.mem_addr;
        d1[nw1] = bif1.mem_wdata;
        c1[nw1] = cyc;
      end
      nw1 = nw1 + 1;
    end
    if (bif2.mem_we === 1'b1) begin
      if (nw2 < 32) begin
        a2[nw2] = bif2.mem_addr;
        d2[nw2] = bif2.mem_wdata;
      end
      nw2 = nw2 + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  // Called just after a negedge; returns just after the negedge
  // following the accepting clock edge, rx_valid still high.
  task automatic send_byte(input int sel, input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    if (sel == 1) begin
      bif1.rx_valid = 1'b1;
      bif1.rx_data  = b;
    end else begin
      bif2.rx_valid = 1'b1;
      bif2.rx_data  = b;
    end
    for (int k = 0; k < 40 && !ok; k++) begin
      if ((sel == 1 && bif1.rx_ready === 1'b1) ||
          (sel != 1 && bif2.rx_ready === 1'b1))
        ok = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_byte dut%0d: byte %h not accepted in 40 cycles",
               sel, b);
    end
  endtask

  task automatic send_seq(input int sel, input logic [7:0] v [8], input int cnt);
    for (int i = 0; i < cnt; i++) send_byte(sel, v[i]);
  endtask

  task automatic idle(input int cycles);
    bif1.rx_valid = 1'b0;
    bif2.rx_valid = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic pulse_start(input int sel);
    if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic test_reset;
    areset = 1'b1;
    #1;
    checks++;
    if (bif1.rx_ready !== 1'b0 || bif1.mem_we !== 1'b0 ||
        bif1.mem_addr !== 32'h0 || bif1.mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: rdy=%b we=%b addr=%h wd=%h want 0 0 0 0",
               bif1.rx_ready, bif1.mem_we, bif1.mem_addr, bif1.mem_wdata);
    end
    checks++;
    if (hold1 !== 1'b1 || done1 !== 1'b0 || err1 !== 1'b0 || wl1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_status: hold=%b done=%b err=%b wl=%0d want 1 0 0 0",
               hold1, done1, err1, wl1);
    end
    checks++;
    if (bif2.mem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL reset_addr2: got %h want fffffffc", bif2.mem_addr);
    end
    @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    checks++;
    if (hold1 !== 1'b1 || bif1.rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: hold=%b rdy=%b want 1 0", hold1, bif1.rx_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] h [8];
    logic [7:0] d [8];
    int base;
    base = nw1;
    h = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    d = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
    pulse_start(1);
    send_seq(1, h, 4);
    send_seq(1, d, 8);
    idle(2);
    checks++;
    if (nw1 - base !== 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d writes want 2", nw1 - base);
    end else begin
      checks++;
      if (a1[base] !== 32'h0 || d1[base] !== 32'h0050_0513) begin
        errors++;
        $display("FAIL b2b_w0: addr=%h data=%h want 00000000 00500513",
                 a1[base], d1[base]);
      end
      checks++;
      if (a1[base+1] !== 32'h4 || d1[base+1] !== 32'h00A0_0593) begin
        errors++;
        $display("FAIL b2b_w1: addr=%h data=%h want 00000004 00a00593",
                 a1[base+1], d1[base+1]);
      end
      checks++;
      if (c1[base+1] - c1[base] !== 5) begin
        errors++;
        $display("FAIL b2b_rate: spacing %0d cycles want 5",
                 c1[base+1] - c1[base]);
      end
    end
    checks++;
    if (done1 !== 1'b1 || hold1 !== 1'b0 || wl1 !== 32'd2) begin
      errors++;
      $display("FAIL b2b_done: done=%b hold=%b wl=%0d want 1 0 2",
               done1, hold1, wl1);
    end
  endtask

  task automatic test_err;
    logic [7:0] h [8];
    int base;
    base = nw1;
    h = '{8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    pulse_start(1);
    send_seq(1, h, 4);
    bif1.rx_data = 8'hAA;
    repeat (3) @(negedge clk);
    checks++;
    if (err1 !== 1'b1 || hold1 !== 1'b1 || bif1.rx_ready !== 1'b0 ||
        done1 !== 1'b0) begin
      errors++;
      $display("FAIL err_state: err=%b hold=%b rdy=%b done=%b want 1 1 0 0",
               err1, hold1, bif1.rx_ready, done1);
    end
    checks++;
    if (nw1 !== base) begin
      errors++;
      $display("FAIL err_nowrite: got %0d writes want 0", nw1 - base);
    end
    idle(1);
    h = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    pulse_start(1);
    send_seq(1, h, 4);
    idle(2);
    checks++;
    if (done1 !== 1'b1 || err1 !== 1'b0 || wl1 !== 32'd0 || nw1 !== base) begin
      errors++;
      $display("FAIL zero_len: done=%b err=%b wl=%0d writes=%0d want 1 0 0 0",
               done1, err1, wl1, nw1 - base);
    end
  endtask

  task automatic test_gaps;
    logic [7:0] h [8];
    int base;
    base = nw1;
    h = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    pulse_start(1);
    send_seq(1, h, 4);
    send_byte(1, 8'hEF);
    idle(2);
    send_byte(1, 8'hBE);
    bif1.rx_valid = 1'b0;
    pulse_start(1);
    idle(1);
    send_byte(1, 8'hAD);
    idle(2);
    send_byte(1, 8'hDE);
    idle(2);
    checks++;
    if (nw1 - base !== 1) begin
      errors++;
      $display("FAIL gaps_count: got %0d writes want 1", nw1 - base);
    end else begin
      checks++;
      if (a1[base] !== 32'h0 || d1[base] !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL gaps_word: addr=%h data=%h want 00000000 deadbeef",
                 a1[base], d1[base]);
      end
    end
    checks++;
    if (done1 !== 1'b1 || wl1 !== 32'd1) begin
      errors++;
      $display("FAIL gaps_done: done=%b wl=%0d want 1 1", done1, wl1);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] h [8];
    logic [7:0] d [8];
    int base;
    h = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    d = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00};
    pulse_start(1);
    send_seq(1, h, 4);
    send_byte(1, 8'h11);
    send_byte(1, 8'h22);
    bif1.rx_valid = 1'b0;
    #1 areset = 1'b1;
    #1;
    checks++;
    if (bif1.rx_ready !== 1'b0 || bif1.mem_we !== 1'b0 ||
        bif1.mem_addr !== 32'h0 || bif1.mem_wdata !== 32'h0 ||
        hold1 !== 1'b1 || done1 !== 1'b0 || err1 !== 1'b0 || wl1 !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b wl=%0d want reset values",
               bif1.rx_ready, bif1.mem_we, bif1.mem_addr, bif1.mem_wdata,
               hold1, done1, err1, wl1);
    end
    @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    base = nw1;
    pulse_start(1);
    send_seq(1, h, 4);
    send_seq(1, d, 4);
    idle(2);
    checks++;
    if (nw1 - base !== 1) begin
      errors++;
      $display("FAIL mid_count: got %0d writes want 1", nw1 - base);
    end else begin
      checks++;
      if (a1[base] !== 32'h0 || d1[base] !== 32'h1234_5678) begin
        errors++;
        $display("FAIL mid_word: addr=%h data=%h want 00000000 12345678",
                 a1[base], d1[base]);
      end
    end
  endtask

  task automatic test_wrap;
    logic [7:0] h [8];
    logic [7:0] d [8];
    int base;
    base = nw2;
    h = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    d = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    pulse_start(2);
    send_seq(2, h, 4);
    send_seq(2, d, 8);
    idle(2);
    checks++;
    if (nw2 - base !== 2) begin
      errors++;
      $display("FAIL wrap_count: got %0d writes want 2", nw2 - base);
    end else begin
      checks++;
      if (a2[base] !== 32'hFFFF_FFFC || d2[base] !== 32'h1) begin
        errors++;
        $display("FAIL wrap_w0: addr=%h data=%h want fffffffc 00000001",
                 a2[base], d2[base]);
      end
      checks++;
      if (a2[base+1] !== 32'h0 || d2[base+1] !== 32'h2) begin
        errors++;
        $display("FAIL wrap_w1: addr=%h data=%h want 00000000 00000002",
                 a2[base+1], d2[base+1]);
      end
    end
    checks++;
    if (done2 !== 1'b1 || hold2 !== 1'b0 || wl2 !== 32'd2) begin
      errors++;
      $display("FAIL wrap_done: done=%b hold=%b wl=%0d want 1 0 2",
               done2, hold2, wl2);
    end
  endtask

  task automatic test_reload;
    logic [7:0] h [8];
    logic [7:0] d [8];
    int base;
    h = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    d = '{8'h67, 8'h45, 8'h23, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    checks++;
    if (done1 !== 1'b1 || hold1 !== 1'b0) begin
      errors++;
      $display("FAIL reload_pre: done=%b hold=%b want 1 0", done1, hold1);
    end
    base = nw1;
    pulse_start(1);
    checks++;
    if (hold1 !== 1'b1 || done1 !== 1'b0 || bif1.rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reload_hold: hold=%b done=%b rdy=%b want 1 0 1",
               hold1, done1, bif1.rx_ready);
    end
    send_seq(1, h, 4);
    send_seq(1, d, 4);
    idle(2);
    checks++;
    if (nw1 - base !== 1) begin
      errors++;
      $display("FAIL reload_count: got %0d writes want 1", nw1 - base);
    end else begin
      checks++;
      if (a1[base] !== 32'h0 || d1[base] !== 32'h0123_4567) begin
        errors++;
        $display("FAIL reload_word: addr=%h data=%h want 00000000 01234567",
                 a1[base], d1[base]);
      end
    end
    checks++;
    if (done1 !== 1'b1 || wl1 !== 32'd1) begin
      errors++;
      $display("FAIL reload_done: done=%b wl=%0d want 1 1", done1, wl1);
    end
  endtask

  initial begin
    areset        = 1'b1;
    start1        = 1'b0;
    start2        = 1'b0;
    bif1.rx_valid = 1'b0;
    bif1.rx_data  = 8'h00;
    bif2.rx_valid = 1'b0;
    bif2.rx_data  = 8'h00;
    test_reset;
    test_back_to_back;
    test_err;
    test_gaps;
    test_reset_mid;
    test_wrap;
    test_reload;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
